// File: rtl/credit_ledger.sv
`default_nettype none
// =============================================================================
// credit_ledger : vending credit register and coin/buy/change sequencer
//                 wrapped around an external 5-bit flag-producing ALU.
// Rev 1.0
// =============================================================================
module credit_ledger #(
  parameter int CREDIT_MAX = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  input  logic       buy_req,
  input  logic [4:0] price,
  input  logic       refund_req,
  input  logic       change_ack,
  output logic [4:0] alu_a,
  output logic [4:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [4:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_negative,
  output logic [4:0] credit,
  output logic       busy,
  output logic       vend,
  output logic       coin_reject,
  output logic       err_funds,
  output logic       change_valid,
  output logic [4:0] change_value
);

  localparam logic [4:0] C_CREDIT_MAX = 5'(CREDIT_MAX);
  localparam logic [1:0] C_OP_ADD     = 2'b00;
  localparam logic [1:0] C_OP_SUB     = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD    = 2'd1,
    ST_SUB    = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic [4:0] op_b_q, op_b_d;
  logic       busy_q, busy_d;
  logic       vend_q, vend_d;
  logic       coin_reject_q, coin_reject_d;
  logic       err_funds_q, err_funds_d;

  // The negative flag carries no information for unsigned credit arithmetic.
  logic unused_alu_negative;
  assign unused_alu_negative = alu_negative;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= 5'd0;
      op_b_q        <= 5'd0;
      busy_q        <= 1'b0;
      vend_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      err_funds_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      op_b_q        <= op_b_d;
      busy_q        <= busy_d;
      vend_q        <= vend_d;
      coin_reject_q <= coin_reject_d;
      err_funds_q   <= err_funds_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    op_b_d        = op_b_q;
    vend_d        = 1'b0;
    coin_reject_d = 1'b0;
    err_funds_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Refund wins arbitration even when it turns out to be a no-op.
        if (refund_req) begin
          if (credit_q != 5'd0) begin
            state_d = ST_CHANGE;
          end
        end else if (buy_req) begin
          op_b_d  = price;
          state_d = ST_SUB;
        end else if (coin_valid) begin
          op_b_d  = coin_value;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        if (alu_carry || (alu_result > C_CREDIT_MAX)) begin
          coin_reject_d = 1'b1;
        end else begin
          credit_d = alu_result;
        end
        state_d = ST_IDLE;
      end
      ST_SUB: begin
        if (alu_carry) begin
          err_funds_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          vend_d   = 1'b1;
          credit_d = alu_result;
          state_d  = alu_zero ? ST_IDLE : ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        if (change_ack) begin
          credit_d = 5'd0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    alu_a  = credit_q;
    alu_b  = 5'd0;
    alu_op = C_OP_ADD;
    if (state_q == ST_ADD) begin
      alu_b = op_b_q;
    end else if (state_q == ST_SUB) begin
      alu_b  = op_b_q;
      alu_op = C_OP_SUB;
    end
  end

  assign credit       = credit_q;
  assign busy         = busy_q;
  assign vend         = vend_q;
  assign coin_reject  = coin_reject_q;
  assign err_funds    = err_funds_q;
  assign change_valid = (state_q == ST_CHANGE);
  assign change_value = change_valid ? credit_q : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_credit_ledger.sv
`default_nettype none
// =============================================================================
// tb_credit_ledger : directed vector bench for credit_ledger with ALU model.
// Rev 1.0
// =============================================================================
module tb_credit_ledger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0 : CREDIT_MAX = 31 ----------------
  logic       rst, coin_valid, buy_req, refund_req, change_ack;
  logic [4:0] coin_value, price;
  logic [4:0] alu_a, alu_b, alu_result, credit, change_value;
  logic [1:0] alu_op;
  logic       alu_carry, alu_zero, alu_negative;
  logic       busy, vend, coin_reject, err_funds, change_valid;

  credit_ledger #(.CREDIT_MAX(31)) u_dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
    .buy_req(buy_req), .price(price), .refund_req(refund_req), .change_ack(change_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .credit(credit), .busy(busy), .vend(vend), .coin_reject(coin_reject),
    .err_funds(err_funds), .change_valid(change_valid), .change_value(change_value)
  );

  always_comb begin
    {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_op == 2'b01) begin
      alu_result = alu_a - alu_b;
      alu_carry  = (alu_a < alu_b);
    end
    alu_zero     = (alu_result == 5'd0);
    alu_negative = alu_result[4];
  end

  // ---------------- DUT 1 : CREDIT_MAX = 20 ----------------
  logic       rst1, coin_valid1;
  logic [4:0] coin_value1;
  logic [4:0] alu_a1, alu_b1, alu_result1, credit1, change_value1;
  logic [1:0] alu_op1;
  logic       alu_carry1, alu_zero1, alu_negative1;
  logic       busy1, vend1, coin_reject1, err_funds1, change_valid1;

  credit_ledger #(.CREDIT_MAX(20)) u_dut20 (
    .clk(clk), .rst(rst1), .coin_valid(coin_valid1), .coin_value(coin_value1),
    .buy_req(1'b0), .price(5'd0), .refund_req(1'b0), .change_ack(1'b0),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_result1),
    .alu_carry(alu_carry1), .alu_zero(alu_zero1), .alu_negative(alu_negative1),
    .credit(credit1), .busy(busy1), .vend(vend1), .coin_reject(coin_reject1),
    .err_funds(err_funds1), .change_valid(change_valid1), .change_value(change_value1)
  );

  always_comb begin
    {alu_carry1, alu_result1} = {1'b0, alu_a1} + {1'b0, alu_b1};
    if (alu_op1 == 2'b01) begin
      alu_result1 = alu_a1 - alu_b1;
      alu_carry1  = (alu_a1 < alu_b1);
    end
    alu_zero1     = (alu_result1 == 5'd0);
    alu_negative1 = alu_result1[4];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One record = inputs applied for one cycle, and outputs expected after that edge.
  typedef struct packed {
    logic       rst;
    logic       cv;
    logic [4:0] cval;
    logic       buy;
    logic [4:0] pr;
    logic       rf;
    logic       ack;
    logic [4:0] e_credit;
    logic       e_busy;
    logic       e_vend;
    logic       e_rej;
    logic       e_err;
    logic       e_chv;
    logic [4:0] e_chval;
    logic [1:0] e_op;
    logic [4:0] e_b;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(
    input logic r, input logic cv, input logic [4:0] cval, input logic b,
    input logic [4:0] pr, input logic rf, input logic ack,
    input logic [4:0] ec, input logic eb, input logic ev, input logic er,
    input logic ee, input logic ecv, input logic [4:0] ecval,
    input logic [1:0] eop, input logic [4:0] ealb);
    vec_t v;
    v = '{r, cv, cval, b, pr, rf, ack, ec, eb, ev, er, ee, ecv, ecval, eop, ealb};
    vecs.push_back(v);
  endtask

  // Shorthands: idle cycle / coin / buy with the expected outputs after the edge.
  task automatic v_idle(input logic [4:0] ec, input logic eb, input logic ev,
                        input logic er, input logic ee, input logic ecv,
                        input logic [4:0] ecval);
    add_vec(0, 0, 0, 0, 0, 0, 0, ec, eb, ev, er, ee, ecv, ecval, 2'b00, 5'd0);
  endtask

  task automatic step1(input logic cv, input logic [4:0] val);
    coin_valid1 = cv;
    coin_value1 = val;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; coin_valid = 0; coin_value = 0; buy_req = 0; price = 0;
    refund_req = 0; change_ack = 0;
    rst1 = 1'b1; coin_valid1 = 0; coin_value1 = 0;

    //      rst cv cval buy pr  rf ack | credit busy vend rej err chv chval op    alu_b
    add_vec(1, 0, 0,   0, 0,  0, 0,    0,  0, 0, 0, 0, 0, 0,  2'b00, 0);   // reset state
    // coins 5 then 10
    add_vec(0, 1, 5,   0, 0,  0, 0,    0,  1, 0, 0, 0, 0, 0,  2'b00, 5);
    v_idle(5, 0, 0, 0, 0, 0, 0);
    v_idle(5, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 10,  0, 0,  0, 0,    5,  1, 0, 0, 0, 0, 0,  2'b00, 10);
    v_idle(15, 0, 0, 0, 0, 0, 0);
    // to 30, then coin 4 overflows
    add_vec(0, 1, 15,  0, 0,  0, 0,    15, 1, 0, 0, 0, 0, 0,  2'b00, 15);
    v_idle(30, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 4,   0, 0,  0, 0,    30, 1, 0, 0, 0, 0, 0,  2'b00, 4);
    v_idle(30, 0, 0, 1, 0, 0, 0);
    v_idle(30, 0, 0, 0, 0, 0, 0);
    // buy 15 from 30 -> change 15, ack in first CHANGE cycle
    add_vec(0, 0, 0,   1, 15, 0, 0,    30, 1, 0, 0, 0, 0, 0,  2'b01, 15);
    v_idle(15, 1, 1, 0, 0, 1, 15);
    add_vec(0, 0, 0,   0, 0,  0, 1,    0,  0, 0, 0, 0, 0, 0,  2'b00, 0);
    // credit 15, buy 15 -> exact, then buy 1 -> insufficient funds
    add_vec(0, 1, 15,  0, 0,  0, 0,    0,  1, 0, 0, 0, 0, 0,  2'b00, 15);
    v_idle(15, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0,   1, 15, 0, 0,    15, 1, 0, 0, 0, 0, 0,  2'b01, 15);
    v_idle(0, 0, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0,   1, 1,  0, 0,    0,  1, 0, 0, 0, 0, 0,  2'b01, 1);
    v_idle(0, 0, 0, 0, 1, 0, 0);
    v_idle(0, 0, 0, 0, 0, 0, 0);
    // credit 20, buy 12 -> change 8 held 5 cycles; strobes during CHANGE ignored
    add_vec(0, 1, 20,  0, 0,  0, 0,    0,  1, 0, 0, 0, 0, 0,  2'b00, 20);
    v_idle(20, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0,   1, 12, 0, 0,    20, 1, 0, 0, 0, 0, 0,  2'b01, 12);
    v_idle(8, 1, 1, 0, 0, 1, 8);
    v_idle(8, 1, 0, 0, 0, 1, 8);
    add_vec(0, 1, 3,   0, 0,  0, 0,    8,  1, 0, 0, 0, 1, 8,  2'b00, 0);
    add_vec(0, 0, 0,   1, 2,  0, 0,    8,  1, 0, 0, 0, 1, 8,  2'b00, 0);
    add_vec(0, 0, 0,   0, 0,  1, 0,    8,  1, 0, 0, 0, 1, 8,  2'b00, 0);
    v_idle(8, 1, 0, 0, 0, 1, 8);
    add_vec(0, 0, 0,   0, 0,  0, 1,    0,  0, 0, 0, 0, 0, 0,  2'b00, 0);
    add_vec(0, 0, 0,   0, 0,  0, 1,    0,  0, 0, 0, 0, 0, 0,  2'b00, 0);  // stray ack
    // credit 9, simultaneous refund/buy/coin -> refund wins
    add_vec(0, 1, 9,   0, 0,  0, 0,    0,  1, 0, 0, 0, 0, 0,  2'b00, 9);
    v_idle(9, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 3,   1, 5,  1, 0,    9,  1, 0, 0, 0, 1, 9,  2'b00, 0);
    v_idle(9, 1, 0, 0, 0, 1, 9);
    add_vec(0, 0, 0,   0, 0,  0, 1,    0,  0, 0, 0, 0, 0, 0,  2'b00, 0);
    add_vec(0, 0, 0,   0, 0,  1, 0,    0,  0, 0, 0, 0, 0, 0,  2'b00, 0);  // refund at 0
    // reset while in CHANGE, then coin 3
    add_vec(0, 1, 8,   0, 0,  0, 0,    0,  1, 0, 0, 0, 0, 0,  2'b00, 8);
    v_idle(8, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0,   0, 0,  1, 0,    8,  1, 0, 0, 0, 1, 8,  2'b00, 0);
    add_vec(1, 0, 0,   0, 0,  0, 0,    0,  0, 0, 0, 0, 0, 0,  2'b00, 0);
    add_vec(0, 1, 3,   0, 0,  0, 0,    0,  1, 0, 0, 0, 0, 0,  2'b00, 3);
    v_idle(3, 0, 0, 0, 0, 0, 0);

    #1;
    foreach (vecs[i]) begin
      rst        = vecs[i].rst;
      coin_valid = vecs[i].cv;
      coin_value = vecs[i].cval;
      buy_req    = vecs[i].buy;
      price      = vecs[i].pr;
      refund_req = vecs[i].rf;
      change_ack = vecs[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.credit", i),       credit,       vecs[i].e_credit);
      chk($sformatf("v%0d.busy", i),         busy,         vecs[i].e_busy);
      chk($sformatf("v%0d.vend", i),         vend,         vecs[i].e_vend);
      chk($sformatf("v%0d.coin_reject", i),  coin_reject,  vecs[i].e_rej);
      chk($sformatf("v%0d.err_funds", i),    err_funds,    vecs[i].e_err);
      chk($sformatf("v%0d.change_valid", i), change_valid, vecs[i].e_chv);
      chk($sformatf("v%0d.change_value", i), change_value, vecs[i].e_chval);
      chk($sformatf("v%0d.alu_op", i),       alu_op,       vecs[i].e_op);
      chk($sformatf("v%0d.alu_b", i),        alu_b,        vecs[i].e_b);
      chk($sformatf("v%0d.alu_a", i),        alu_a,        vecs[i].e_credit);
    end
    rst = 1'b0; coin_valid = 0; buy_req = 0; refund_req = 0; change_ack = 0;

    // CREDIT_MAX = 20: 18 + 5 exceeds the ceiling without carry; 18 + 2 lands on it.
    rst1 = 1'b1;
    step1(0, 0);
    rst1 = 1'b0;
    chk("m20.reset_credit", credit1, 0);
    step1(1, 18);
    chk("m20.busy_add", busy1, 1);
    step1(0, 0);
    chk("m20.credit18", credit1, 18);
    step1(1, 5);
    chk("m20.alu_b", alu_b1, 5);
    step1(0, 0);
    chk("m20.reject", coin_reject1, 1);
    chk("m20.credit_kept", credit1, 18);
    step1(0, 0);
    chk("m20.reject_width", coin_reject1, 0);
    step1(1, 2);
    step1(0, 0);
    chk("m20.credit20", credit1, 20);
    chk("m20.no_reject", coin_reject1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
